// File: rtl/mul_seq_64_pkg.sv
// rtl/mul_seq_64_pkg.sv - shared constants and state encoding for the sequential multiplier
// Purpose: operand width, iteration counter width, fixed latency and FSM states.
// Ports: none (package).
package mul_seq_64_pkg;

    localparam int WIDTH   = 64;
    localparam int CNT_W   = 7;
    // Edges from the accepting edge to the edge that enters DONE: 2 negate + 64 iterate + 1 fix.
    localparam int LATENCY = 67;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NEGA = 3'd1,
        S_NEGB = 3'd2,
        S_ITER = 3'd3,
        S_FIX  = 3'd4,
        S_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/mul_seq_64_adder.sv
// rtl/mul_seq_64_adder.sv - 64-bit two's complement adder shared by the multiplier datapath
// Purpose: combinational sum of two 64-bit operands plus signed-overflow indication.
// Ports:
//   a_i        - addend A
//   b_i        - addend B
//   sum_o      - A + B modulo 2^64
//   overflow_o - signed overflow of A + B
module adder_64 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic [63:0] sum_o,
    output logic        overflow_o
);

    assign sum_o      = a_i + b_i;
    assign overflow_o = (a_i[63] == b_i[63]) && (sum_o[63] != a_i[63]);

endmodule

// File: rtl/mul_seq_64.sv
// rtl/mul_seq_64.sv - multi-cycle signed 64x64 multiplier built around one shared adder
// Purpose: sign-magnitude shift-add multiply; returns the low 64 bits and signed overflow.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   start    - operation request, accepted only in IDLE
//   a, b     - signed operands, sampled on the accepting edge
//   busy     - high in every state except IDLE
//   done     - one-cycle pulse when result/overflow are valid
//   result   - low 64 bits of a*b
//   overflow - true product does not fit in signed 64 bits
module mul_seq_64
    import mul_seq_64_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   mag_a_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic [WIDTH-1:0]   result_q;
    logic               overflow_q;

    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               adder_ovf_unused;
    logic               carry;
    logic [WIDTH-1:0]   lo_s;
    logic               ovf;

    // The single adder is steered by state; idle states present zeros.
    always_comb begin
        add_a = '0;
        add_b = '0;
        unique case (state_q)
            S_NEGA: begin
                add_a = ~a_q;
                add_b = WIDTH'(1);
            end
            S_NEGB: begin
                add_a = ~b_q;
                add_b = WIDTH'(1);
            end
            S_ITER: begin
                add_a = hi_q;
                add_b = lo_q[0] ? mag_a_q : '0;
            end
            S_FIX: begin
                add_a = ~lo_q;
                add_b = WIDTH'(1);
            end
            default: begin
                add_a = '0;
                add_b = '0;
            end
        endcase
    end

    adder_64 u_adder (
        .a_i        (add_a),
        .b_i        (add_b),
        .sum_o      (add_sum),
        .overflow_o (adder_ovf_unused)
    );

    // Unsigned carry-out recovered from the MSBs of inputs and sum.
    assign carry = (add_a[WIDTH-1] & add_b[WIDTH-1])
                 | ((add_a[WIDTH-1] | add_b[WIDTH-1]) & ~add_sum[WIDTH-1]);

    assign lo_s = neg_q ? add_sum : lo_q;

    // A negative result may reach exactly -2^63; a positive one must stay below 2^63.
    assign ovf = (hi_q != '0)
               | (neg_q ? (lo_q[WIDTH-1] & (|lo_q[WIDTH-2:0])) : lo_q[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            mag_a_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                        state_q <= S_NEGA;
                    end
                end
                S_NEGA: begin
                    mag_a_q <= a_q[WIDTH-1] ? add_sum : a_q;
                    state_q <= S_NEGB;
                end
                S_NEGB: begin
                    hi_q    <= '0;
                    lo_q    <= b_q[WIDTH-1] ? add_sum : b_q;
                    cnt_q   <= '0;
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    // {hi, lo} <= {carry, sum, lo} >> 1
                    hi_q  <= {carry, add_sum[WIDTH-1:1]};
                    lo_q  <= {add_sum[0], lo_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q   <= lo_s;
                    overflow_q <= ovf;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mul_seq_64.sv
// tb/tb_mul_seq_64.sv - directed self-checking bench for mul_seq_64
module tb_mul_seq_64;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        overflow;

    int checks;
    int failures;

    mul_seq_64 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts one op from IDLE, waits (bounded) for done, checks latency, busy, result, hold.
    task automatic run_op(input string tag, input logic [63:0] opa, input logic [63:0] opb,
                          input logic [63:0] exp_r, input logic exp_o);
        int   cyc;
        logic busy_ok;
        cyc     = 0;
        busy_ok = 1'b1;
        a       = opa;
        b       = opb;
        start   = 1'b1;
        do begin
            tick();
            start = 1'b0;
            cyc++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end while (done !== 1'b1 && cyc < 200);
        chk({tag, "_latency"}, 64'(cyc), 64'd68);
        chk({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
        chk({tag, "_result"}, result, exp_r);
        chk({tag, "_ovf"}, {63'd0, overflow}, {63'd0, exp_o});
        tick();
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        chk({tag, "_hold"}, result, exp_r);
    endtask

    initial begin
        int cyc;
        int ndone;
        int first_done;
        int second_done;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        tick();
        tick();
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_ovf", {63'd0, overflow}, 64'd0);
        rst = 1'b0;
        tick();

        run_op("3x5",       64'd3,                  64'd5,                  64'd15,                  1'b0);
        run_op("m7x6",      64'hFFFF_FFFF_FFFF_FFF9, 64'd6,                  64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
        run_op("m7xm6",     64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFA, 64'd42,                  1'b0);
        run_op("2p32sq",    64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd0,                   1'b1);
        run_op("2p62x2",    64'h4000_0000_0000_0000, 64'd2,                  64'h8000_0000_0000_0000, 1'b1);
        run_op("m2p62x2",   64'hC000_0000_0000_0000, 64'd2,                  64'h8000_0000_0000_0000, 1'b0);
        run_op("m2p63xm1",  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1);
        run_op("m2p63x0",   64'h8000_0000_0000_0000, 64'd0,                  64'd0,                   1'b0);

        // A start pulse with new operands during ITER must be ignored.
        a     = 64'd7;
        b     = 64'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        ndone = 0;
        first_done = 0;
        repeat (15) begin
            tick();
            cyc++;
        end
        a     = 64'd1000;
        b     = 64'd1000;
        start = 1'b1;
        tick();
        cyc++;
        start = 1'b0;
        a     = 64'd0;
        b     = 64'd0;
        while (cyc < 170) begin
            if (done === 1'b1) begin
                ndone++;
                if (first_done == 0) first_done = cyc;
            end
            tick();
            cyc++;
        end
        chk("stray_first_done", 64'(first_done), 64'd68);
        chk("stray_ndone", 64'(ndone), 64'd1);
        chk("stray_result", result, 64'd63);
        chk("stray_busy", {63'd0, busy}, 64'd0);

        // One-cycle reset during ITER aborts the op.
        a     = 64'd3;
        b     = 64'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_ovf", {63'd0, overflow}, 64'd0);
        ndone = 0;
        repeat (100) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        run_op("after_abort", 64'd3, 64'd5, 64'd15, 1'b0);

        // start held high: back-to-back ops, one per 69 cycles.
        a     = 64'hFFFF_FFFF_FFFF_FFF9;
        b     = 64'hFFFF_FFFF_FFFF_FFFA;
        start = 1'b1;
        cyc   = 0;
        ndone = 0;
        first_done  = 0;
        second_done = 0;
        while (cyc < 220) begin
            tick();
            cyc++;
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) first_done = cyc;
                if (ndone == 2) begin
                    second_done = cyc;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_first", 64'(first_done), 64'd68);
        chk("b2b_second", 64'(second_done), 64'd137);
        chk("b2b_ndone", 64'(ndone), 64'd2);
        chk("b2b_result", result, 64'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
